// File: rtl/store_buffer_bm.sv
// rtl/store_buffer_bm.sv - in-order store buffer with commit, flush, dcache drain and load forwarding (macro STORE_BUFFER_FWD_EN)
module store_buffer_bm #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int BE_W  = DATA_W / 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic [IDX_W-1:0]  req_idx_o,
  input  logic              commit_valid_i,
  input  logic [IDX_W-1:0]  commit_idx_i,
  input  logic              discard_i,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [BE_W-1:0]   ld_be_i,
  output logic              ld_hit_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              ld_conflict_o,
  output logic              dc_req_valid_o,
  input  logic              dc_req_ready_i,
  output logic [ADDR_W-1:0] dc_addr_o,
  output logic [DATA_W-1:0] dc_data_o,
  output logic [BE_W-1:0]   dc_be_o,
  output logic              empty_o,
  output logic [IDX_W:0]    count_o
);

  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = $clog2(BE_W);
  localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [1:0] {E_FREE, E_PENDING, E_COMMITTED} entry_st_e;
  typedef enum logic [0:0] {D_IDLE, D_ISSUE} drain_st_e;

  entry_st_e         st_q   [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];

  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d, npend;
  drain_st_e         drain_q, drain_d;
  logic [ADDR_W-1:0] dc_addr_q;
  logic [DATA_W-1:0] dc_data_q;
  logic [BE_W-1:0]   dc_be_q;
  logic              dc_load, drain_done, alloc, commit_hit;

  assign req_ready_o    = (count_q < CNT_W'(DEPTH));
  assign req_idx_o      = tail_q;
  assign empty_o        = (count_q == '0);
  assign count_o        = count_q;
  assign dc_req_valid_o = (drain_q == D_ISSUE);
  assign dc_addr_o      = dc_addr_q;
  assign dc_data_o      = dc_data_q;
  assign dc_be_o        = dc_be_q;
  assign alloc          = req_valid_i && req_ready_o;
  assign commit_hit     = commit_valid_i && (st_q[commit_idx_i] == E_PENDING);

  // Drain FSM next state: pick up a committed head, hold the dcache write until accepted
  always_comb begin
    drain_d    = drain_q;
    dc_load    = 1'b0;
    drain_done = 1'b0;
    case (drain_q)
      D_IDLE: begin
        if (st_q[head_q] == E_COMMITTED) begin
          drain_d = D_ISSUE;
          dc_load = 1'b1;
        end
      end
      D_ISSUE: begin
        if (dc_req_ready_i) begin
          drain_d    = D_IDLE;
          drain_done = 1'b1;
        end
      end
      default: drain_d = D_IDLE;
    endcase
  end

  // Pointer/count next state; a flush removes pending entries not being committed this cycle
  always_comb begin
    npend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] == E_PENDING && !(commit_hit && commit_idx_i == IDX_W'(i))) begin
        npend = npend + CNT_W'(1);
      end
    end
    head_d = drain_done ? head_q + IDX_W'(1) : head_q;
    if (discard_i) begin
      tail_d  = tail_q - npend[IDX_W-1:0];
      count_d = count_q - npend - CNT_W'(drain_done);
    end else begin
      tail_d  = alloc ? tail_q + IDX_W'(1) : tail_q;
      count_d = count_q + CNT_W'(alloc) - CNT_W'(drain_done);
    end
  end

  // Drain FSM state register and dcache request fields
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drain_q   <= D_IDLE;
      dc_addr_q <= '0;
      dc_data_q <= '0;
      dc_be_q   <= '0;
    end else begin
      drain_q <= drain_d;
      if (dc_load) begin
        dc_addr_q <= addr_q[head_q];
        dc_data_q <= data_q[head_q];
        dc_be_q   <= be_q[head_q];
      end
    end
  end

  // Pointers, count and per-entry state (flush, commit, drain free, allocate)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) st_q[i] <= E_FREE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_hit && commit_idx_i == IDX_W'(i)) begin
          st_q[i] <= E_COMMITTED;
        end else if (discard_i && st_q[i] == E_PENDING) begin
          st_q[i] <= E_FREE;
        end
      end
      if (drain_done) st_q[head_q] <= E_FREE;
      if (alloc && !discard_i) st_q[tail_q] <= E_PENDING;
    end
  end

  // Entry payload; written on any accepted request, meaningless while the entry is FREE
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      addr_q[tail_q] <= req_addr_i & WORD_MASK;
      data_q[tail_q] <= req_data_i;
      be_q[tail_q]   <= req_be_i;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [BE_W-1:0]   fwd_match_be, fwd_cov;
  logic [DATA_W-1:0] fwd_data, fwd_mask;
  logic [IDX_W-1:0]  age_idx;

  // Byte-merge forwarding: walk oldest to youngest so the youngest writer of each lane wins
  always_comb begin
    fwd_match_be = '0;
    fwd_data     = '0;
    fwd_mask     = '0;
    age_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age_idx = head_q + IDX_W'(k);
      if (st_q[age_idx] != E_FREE && (ld_addr_i & WORD_MASK) == addr_q[age_idx]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_q[age_idx][b]) begin
            fwd_match_be[b]    = 1'b1;
            fwd_data[8*b +: 8] = data_q[age_idx][8*b +: 8];
          end
        end
      end
    end
    fwd_cov = fwd_match_be & ld_be_i;
    for (int b = 0; b < BE_W; b++) fwd_mask[8*b +: 8] = {8{fwd_cov[b]}};
    ld_hit_o      = ld_valid_i && (fwd_cov != '0) && (fwd_cov == ld_be_i);
    ld_conflict_o = ld_valid_i && (fwd_cov != '0) && (fwd_cov != ld_be_i);
    ld_data_o     = ld_valid_i ? (fwd_data & fwd_mask) : '0;
  end
`else
  // No forwarding: any overlapping buffered store makes the load wait for the drain
  always_comb begin
    ld_hit_o      = 1'b0;
    ld_data_o     = '0;
    ld_conflict_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_valid_i && st_q[i] != E_FREE && (ld_addr_i & WORD_MASK) == addr_q[i] &&
          (be_q[i] & ld_be_i) != '0) begin
        ld_conflict_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer_bm.sv
// tb/tb_store_buffer_bm.sv - self-checking bench for store_buffer_bm
module tb_store_buffer_bm;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int BE_W   = 4;
  localparam int IDX_W  = 2;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic [BE_W-1:0]   req_be = '0;
  logic [IDX_W-1:0]  req_idx;
  logic              commit_valid = 1'b0;
  logic [IDX_W-1:0]  commit_idx = '0;
  logic              discard = 1'b0;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [BE_W-1:0]   ld_be = '0;
  logic              ld_hit, ld_conflict;
  logic [DATA_W-1:0] ld_data;
  logic              dc_valid;
  logic              dc_ready = 1'b0;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_data;
  logic [BE_W-1:0]   dc_be;
  logic              empty;
  logic [IDX_W:0]    count;

  store_buffer_bm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_be_i(req_be), .req_idx_o(req_idx),
    .commit_valid_i(commit_valid), .commit_idx_i(commit_idx), .discard_i(discard),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_be_i(ld_be),
    .ld_hit_o(ld_hit), .ld_data_o(ld_data), .ld_conflict_o(ld_conflict),
    .dc_req_valid_o(dc_valid), .dc_req_ready_i(dc_ready), .dc_addr_o(dc_addr),
    .dc_data_o(dc_data), .dc_be_o(dc_be), .empty_o(empty), .count_o(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } dc_wr_t;
  dc_wr_t exp_q[$];

  typedef struct {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic              hit_f;
    logic              conf_f;
    logic [DATA_W-1:0] data_f;
    logic              conf_n;
  } ld_vec_t;
  ld_vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
    req_valid = 1'b1; req_addr = a; req_data = d; req_be = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic commit(input logic [IDX_W-1:0] i);
    commit_valid = 1'b1; commit_idx = i;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
    dc_wr_t w;
    w.addr = a; w.data = d; w.be = b;
    exp_q.push_back(w);
  endtask

  task automatic wait_empty(input int budget, input string name);
    for (int n = 0; n < budget && !empty; n++) tick();
    check(name, empty, 1'b1);
  endtask

  // Scoreboard of dcache writes, sampled on the falling edge before the accepting edge
  always @(negedge clk) begin
    if (!rst && dc_valid && dc_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dc_unexpected: actual addr=0x%0h data=0x%0h required=no write", dc_addr, dc_data);
      end else begin
        dc_wr_t w;
        w = exp_q.pop_front();
        check("dc_addr", dc_addr, w.addr);
        check("dc_data", dc_data, w.data);
        check("dc_be", dc_be, w.be);
      end
    end
  end

  initial begin
    //                 vld addr       be       hit conf data_f        conf_n
    vecs[0] = '{1'b1, 32'h200, 4'b0011, 1'b1, 1'b0, 32'h0000BBAA, 1'b1};
    vecs[1] = '{1'b1, 32'h200, 4'b1111, 1'b0, 1'b1, 32'h0000BBAA, 1'b1};
    vecs[2] = '{1'b1, 32'h202, 4'b0001, 1'b1, 1'b0, 32'h000000AA, 1'b1};
    vecs[3] = '{1'b1, 32'h204, 4'b1111, 1'b0, 1'b0, 32'h00000000, 1'b0};
    vecs[4] = '{1'b1, 32'h200, 4'b1100, 1'b0, 1'b0, 32'h00000000, 1'b0};
    vecs[5] = '{1'b1, 32'h200, 4'b0000, 1'b0, 1'b0, 32'h00000000, 1'b0};
    vecs[6] = '{1'b0, 32'h200, 4'b0011, 1'b0, 1'b0, 32'h00000000, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_req_idx", req_idx, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 0);
    check("rst_dc_valid", dc_valid, 1'b0);
    check("rst_ld_hit", ld_hit, 1'b0);
    check("rst_ld_conflict", ld_conflict, 1'b0);
    check("rst_ld_data", ld_data, 0);

    // Fill the buffer, nothing drains without commits
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_addr = 32'h100 + 32'(4 * k); req_data = 32'h1000 + 32'(k); req_be = 4'hF;
      #1;
      check("fill_req_idx", req_idx, k);
      push_exp(32'h100 + 32'(4 * k), 32'h1000 + 32'(k), 4'hF);
      tick();
    end
    req_valid = 1'b0;
    check("full_req_ready", req_ready, 1'b0);
    check("full_count", count, 4);
    repeat (3) tick();
    check("nocommit_dc_valid", dc_valid, 1'b0);

    // Commit entry 0 and drain it with the dcache ready
    dc_ready = 1'b1;
    commit(2'd0);
    check("drain_valid_early", dc_valid, 1'b0);
    tick();
    check("drain_valid", dc_valid, 1'b1);
    check("drain_addr", dc_addr, 32'h100);
    check("drain_ready_still0", req_ready, 1'b0);
    check("drain_count_before", count, 4);
    tick();
    check("drain_count_after", count, 3);
    check("drain_ready_after", req_ready, 1'b1);
    check("drain_valid_after", dc_valid, 1'b0);

    // Backpressure: dcache outputs hold steady for 5 cycles
    dc_ready = 1'b0;
    commit(2'd1);
    tick();
    check("bp_valid", dc_valid, 1'b1);
    for (int n = 0; n < 5; n++) begin
      tick();
      check("bp_hold_valid", dc_valid, 1'b1);
      check("bp_hold_addr", dc_addr, 32'h104);
      check("bp_hold_data", dc_data, 32'h1001);
      check("bp_hold_be", dc_be, 4'hF);
    end
    check("bp_count_hold", count, 3);
    dc_ready = 1'b1;
    tick();
    check("bp_count_accept", count, 2);
    check("bp_valid_after", dc_valid, 1'b0);
    repeat (3) tick();
    check("bp_count_idle", count, 2);

    // Commit the rest and drain to empty
    commit(2'd2);
    commit(2'd3);
    wait_empty(20, "drain_all_empty");
    check("drain_all_queue", exp_q.size(), 0);

    // Forwarding table
    store(32'h200, 32'h000000AA, 4'b0001);
    store(32'h200, 32'h0000BB00, 4'b0010);
    for (int v = 0; v < 7; v++) begin
      ld_valid = vecs[v].vld; ld_addr = vecs[v].addr; ld_be = vecs[v].be;
      #1;
      check($sformatf("ld%0d_hit", v), ld_hit, FWD ? vecs[v].hit_f : 1'b0);
      check($sformatf("ld%0d_conflict", v), ld_conflict, FWD ? vecs[v].conf_f : vecs[v].conf_n);
      check($sformatf("ld%0d_data", v), ld_data, FWD ? vecs[v].data_f : 32'h0);
    end
    ld_valid = 1'b0;

    // Youngest store wins per lane
    store(32'h200, 32'h000000CC, 4'b0001);
    ld_valid = 1'b1; ld_addr = 32'h200; ld_be = 4'b0011;
    #1;
    check("young_hit", ld_hit, FWD);
    check("young_conflict", ld_conflict, !FWD);
    check("young_data", ld_data, FWD ? 32'h0000BBCC : 32'h0);
    ld_valid = 1'b0;

    // Flush everything pending
    check("pre_flush_count", count, 3);
    discard = 1'b1;
    tick();
    discard = 1'b0;
    check("flush_all_count", count, 0);
    check("flush_all_idx", req_idx, 0);

    // Entries 0,1 committed, 2,3 pending, flush with a request while full
    dc_ready = 1'b0;
    for (int k = 0; k < 4; k++) store(32'h400 + 32'(4 * k), 32'hD000 + 32'(k), 4'hF);
    push_exp(32'h400, 32'hD000, 4'hF);
    push_exp(32'h404, 32'hD001, 4'hF);
    commit(2'd0);
    commit(2'd1);
    tick();
    discard = 1'b1;
    req_valid = 1'b1; req_addr = 32'h700; req_data = 32'hDEAD; req_be = 4'hF;
    tick();
    discard = 1'b0;
    req_valid = 1'b0;
    check("flush_count", count, 2);
    check("flush_req_idx", req_idx, 2);
    check("flush_req_ready", req_ready, 1'b1);

    // Flush, commit and allocation in one cycle: commit wins, allocation dropped
    store(32'h500, 32'h5555, 4'b0110);
    push_exp(32'h500, 32'h5555, 4'b0110);
    discard = 1'b1;
    commit_valid = 1'b1; commit_idx = 2'd2;
    req_valid = 1'b1; req_addr = 32'h600; req_data = 32'h6666; req_be = 4'hF;
    tick();
    discard = 1'b0; commit_valid = 1'b0; req_valid = 1'b0;
    check("flush_commit_count", count, 3);
    check("flush_commit_idx", req_idx, 3);
    dc_ready = 1'b1;
    wait_empty(40, "flush_drain_empty");
    check("flush_drain_queue", exp_q.size(), 0);

    // Wrap-around: 10 store/commit/drain rounds starting at index 3
    for (int k = 0; k < 10; k++) begin
      req_valid = 1'b1; req_addr = 32'h800 + 32'(4 * k); req_data = 32'h01010101 * 32'(k + 1); req_be = 4'hF;
      #1;
      check($sformatf("wrap%0d_idx", k), req_idx, (3 + k) % 4);
      push_exp(32'h800 + 32'(4 * k), 32'h01010101 * 32'(k + 1), 4'hF);
      tick();
      req_valid = 1'b0;
      commit(IDX_W'((3 + k) % 4));
      wait_empty(20, "wrap_empty");
    end
    check("wrap_queue", exp_q.size(), 0);

    // Reset mid-drain abandons the write
    dc_ready = 1'b0;
    store(32'h900, 32'h9999, 4'hF);
    commit(2'd1);
    for (int n = 0; n < 10 && !dc_valid; n++) tick();
    check("middrain_valid", dc_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("middrain_rst_valid", dc_valid, 1'b0);
    check("middrain_rst_count", count, 0);
    check("middrain_rst_empty", empty, 1'b1);
    check("middrain_rst_idx", req_idx, 0);
    dc_ready = 1'b1;
    repeat (5) tick();
    check("middrain_no_write", dc_valid, 1'b0);
    check("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_buffer_bm.md
Name: store_buffer_bm

Overview:
- Parametrised successor to the single-purpose store buffer in the mem stage.
- Holds DEPTH in-order stores with per-byte enables.
- Retires stores to the dcache only after the writeback stage commits them, and drops uncommitted stores on a pipeline flush.
- Forwards load data by byte-wise merge across all matching entries, and flags loads that are only partially covered.
- Sits between the mem stage (store/load requests), the writeback stage (commit) and the dcache write port.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; must be a multiple of 8. BE_W = DATA_W/8.
- DEPTH, 4, number of entries; power of two, at least 2. IDX_W = $clog2(DEPTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  store allocation request.
- req_ready_o  out  1  entry free (count < DEPTH); registered-state only.
- req_addr_i  in  ADDR_W  store address; word-aligned, low log2(BE_W) bits ignored.
- req_data_i  in  DATA_W  store data, byte lanes aligned.
- req_be_i  in  BE_W  store byte enables.
- req_idx_o  out  IDX_W  index that the current request is allocated into (tail pointer).
- commit_valid_i  in  1  commit one entry.
- commit_idx_i  in  IDX_W  entry to commit.
- discard_i  in  1  flush: drop all PENDING entries.
- ld_valid_i  in  1  load lookup.
- ld_addr_i  in  ADDR_W  load address.
- ld_be_i  in  BE_W  load byte enables.
- ld_hit_o  out  1  all requested bytes covered by buffered stores.
- ld_data_o  out  DATA_W  merged forwarding data; zero in uncovered lanes.
- ld_conflict_o  out  1  some, but not all, requested bytes covered; load must stall.
- dc_req_valid_o  out  1  write request to dcache.
- dc_req_ready_i  in  1  dcache accepts the write.
- dc_addr_o  out  ADDR_W  write address, word-aligned.
- dc_data_o  out  DATA_W  write data.
- dc_be_o  out  BE_W  write byte enables.
- empty_o  out  1  no valid entries.
- count_o  out  IDX_W+1  number of valid entries.

Behaviour:
- Storage is a circular FIFO with head, tail and count. Per-entry state: FREE, PENDING or COMMITTED.
- Reset (rst_i=1 at a clock edge):
  - All entries FREE; head=tail=0; count=0.
  - Outputs: req_ready_o=1, req_idx_o=0, empty_o=1, count_o=0, dc_req_valid_o=0, ld_hit_o=0, ld_conflict_o=0, ld_data_o=0.
  - Reset asserted mid-drain abandons the in-flight write; nothing is retained.
- Allocation:
  - req_valid_i && req_ready_o writes addr/data/be into the tail entry as PENDING and increments tail (wraps at DEPTH).
  - A request with req_be_i==0 is still allocated.
- Commit:
  - commit_valid_i marks entry commit_idx_i COMMITTED on the next edge.
  - Commit to an entry that is not PENDING is ignored.
  - Commits arrive in program order, so PENDING entries are always a contiguous youngest run.
- Discard:
  - discard_i frees every PENDING entry; tail rewinds to the oldest PENDING entry.
  - An allocation in the same cycle is also discarded.
  - A commit in the same cycle wins for its entry, which is retained as COMMITTED.
  - COMMITTED entries, including an in-flight head, are unaffected.
- Drain FSM, IDLE -> ISSUE -> IDLE:
  - IDLE: if the head entry is COMMITTED, go to ISSUE and latch head fields into the dc_* registers; dc_req_valid_o rises the cycle after entry.
  - ISSUE: hold dc_req_valid_o, dc_addr_o, dc_data_o and dc_be_o stable until dc_req_ready_i.
  - On the accept edge: free head, increment head, return to IDLE.
  - Minimum 2 cycles per drained store.
- Simultaneous events:
  - Allocation and drain in the same cycle: count is unchanged.
  - When full, req_ready_o stays 0 in the cycle a drain completes; it rises on the next cycle. There is no combinational path from dc_req_ready_i to req_ready_o.
- Forwarding (combinational, valid only when ld_valid_i):
  - Compare ld_addr_i word address against all non-FREE entries.
  - For each byte lane, take the youngest matching entry with that be bit set.
  - covered = OR of matching be, ANDed with ld_be_i.
  - covered == ld_be_i (and ld_be_i != 0) -> ld_hit_o=1.
  - covered != 0 and covered != ld_be_i -> ld_conflict_o=1.
  - Otherwise both 0.
  - ld_hit_o and ld_conflict_o are mutually exclusive; both are 0 when ld_valid_i=0.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- Defined: byte-merge forwarding as described in Behaviour.
- Undefined:
  - ld_hit_o is tied to 0 and ld_data_o to 0.
  - ld_conflict_o=1 whenever any non-FREE entry matches the word address with overlapping be, so the load waits until the buffer drains.

Test Plan:
- Reset, then 4 stores to 0x100, 0x104, 0x108, 0x10C -> req_idx_o 0,1,2,3; req_ready_o=0; count_o=4; dc_req_valid_o stays 0 with no commits.
- Commit idx0, dc_req_ready_i=1 -> dc_req_valid_o asserts 2 cycles after commit with dc_addr_o=0x100; count_o=3 after accept; req_ready_o=1 the cycle after.
- Hold dc_req_ready_i=0 for 5 cycles during ISSUE -> dc_* signals stable throughout; a single accept then frees exactly one entry.
- Store 0x200 data 0x000000AA be 0001, then store 0x200 data 0x0000BB00 be 0010:
  - Load 0x200 be 0011 -> ld_hit_o=1, ld_data_o=0x0000BBAA.
  - Load 0x200 be 1111 -> ld_conflict_o=1.
  - With the macro undefined, both loads -> ld_conflict_o=1.
- Entries 0,1 COMMITTED and 2,3 PENDING, then discard_i together with a new request -> count_o=2, next req_idx_o=2, discarded data never reaches the dcache.
- Wrap-around: 10 store/commit/drain cycles with DEPTH=4 -> dcache writes appear in program order; indices wrap 3 -> 0.
